// File: rtl/inert_avg.sv
// Windowed moving average of three signed inertial angle channels over the
// last 2^AVG_LOG2 accepted samples, with a FILL/RUN window controller.
module inert_avg #(
   parameter int AVG_LOG2 = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               vld,
   input  logic signed [15:0] ptch,
   input  logic signed [15:0] roll,
   input  logic signed [15:0] yaw,
   output logic               avg_vld,
   output logic signed [15:0] ptch_avg,
   output logic signed [15:0] roll_avg,
   output logic signed [15:0] yaw_avg,
   output logic               full
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = 16 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                   state_q;
   logic [AVG_LOG2-1:0]      wptr_q;
   logic [CW-1:0]            cnt_q;
   logic signed [SW-1:0]     sum_q   [3];
   logic signed [15:0]       avg_q   [3];
   logic signed [15:0]       buf_q   [3][N];
   logic                     avg_vld_q;
   logic                     full_q;

   logic signed [15:0]       samp_s  [3];
   logic signed [15:0]       old_s   [3];
   logic signed [SW-1:0]     sum_d   [3];
   logic signed [15:0]       avg_d   [3];
   logic                     fill_done_s;

   function automatic logic signed [SW-1:0] sext(input logic signed [15:0] v);
      return {{AVG_LOG2{v[15]}}, v};
   endfunction

   // Next running sums and floor-divided means for the sample on the inputs
   always_comb begin
      samp_s[0] = ptch;
      samp_s[1] = roll;
      samp_s[2] = yaw;
      for (int c = 0; c < 3; c++) begin
         if (state_q == RUN) begin
            old_s[c] = buf_q[c][wptr_q];
         end else begin
            old_s[c] = 16'sd0;
         end
         sum_d[c] = sum_q[c] + sext(samp_s[c]) - sext(old_s[c]);
         // Upper 16 bits of the sum are the arithmetic shift right by AVG_LOG2.
         avg_d[c] = sum_d[c][AVG_LOG2 +: 16];
      end
      fill_done_s = (cnt_q == CNT_LAST);
   end

   // Window controller, running sums and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILL;
         wptr_q    <= '0;
         cnt_q     <= '0;
         avg_vld_q <= 1'b0;
         full_q    <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            sum_q[c] <= '0;
            avg_q[c] <= 16'sd0;
         end
      end else if (clr) begin
         state_q   <= FILL;
         wptr_q    <= '0;
         cnt_q     <= '0;
         avg_vld_q <= 1'b0;
         full_q    <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            sum_q[c] <= '0;
         end
      end else if (vld) begin
         wptr_q <= wptr_q + AVG_LOG2'(1'b1);
         for (int c = 0; c < 3; c++) begin
            sum_q[c] <= sum_d[c];
         end
         if (state_q == FILL) begin
            cnt_q <= cnt_q + CW'(1'b1);
            if (fill_done_s) begin
               state_q   <= RUN;
               full_q    <= 1'b1;
               avg_vld_q <= 1'b1;
               for (int c = 0; c < 3; c++) begin
                  avg_q[c] <= avg_d[c];
               end
            end else begin
               avg_vld_q <= 1'b0;
            end
         end else begin
            full_q    <= 1'b1;
            avg_vld_q <= 1'b1;
            for (int c = 0; c < 3; c++) begin
               avg_q[c] <= avg_d[c];
            end
         end
      end else begin
         avg_vld_q <= 1'b0;
      end
   end

   // Sample storage needs no reset: FILL rewrites every entry before RUN reads it
   always_ff @(posedge clk) begin
      if (vld && !clr) begin
         for (int c = 0; c < 3; c++) begin
            buf_q[c][wptr_q] <= samp_s[c];
         end
      end
   end

   assign avg_vld  = avg_vld_q;
   assign full     = full_q;
   assign ptch_avg = avg_q[0];
   assign roll_avg = avg_q[1];
   assign yaw_avg  = avg_q[2];

endmodule
